// File: rtl/mem_pkg.sv
// Shared encodings for the memory access stage: funct3 sizes, FSM states,
// and default MMIO port addresses.
package mem_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_RESP, ST_IO_IN, ST_IO_OUT} mau_state_e;

   localparam logic [31:0] MMIO_IN_DEF  = 32'h0000_0000;
   localparam logic [31:0] MMIO_OUT_DEF = 32'h0000_0004;
endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus plus the MMIO input/output handshakes.
interface mem_access_unit_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 20
);
   logic                dm_req;
   logic                dm_we;
   logic [ADDR_W-1:0]   dm_addr;
   logic [XLEN-1:0]     dm_wdata;
   logic [XLEN/8-1:0]   dm_be;
   logic                dm_ready;
   logic                dm_rvalid;
   logic [XLEN-1:0]     dm_rdata;
   logic                io_in_valid;
   logic [XLEN-1:0]     io_in_data;
   logic                io_in_ready;
   logic                io_out_valid;
   logic [7:0]          io_out_data;
   logic                io_out_ready;

   modport master (
      output dm_req, dm_we, dm_addr, dm_wdata, dm_be, io_in_ready, io_out_valid, io_out_data,
      input  dm_ready, dm_rvalid, dm_rdata, io_in_valid, io_in_data, io_out_ready
   );
   modport slave (
      input  dm_req, dm_we, dm_addr, dm_wdata, dm_be, io_in_ready, io_out_valid, io_out_data,
      output dm_ready, dm_rvalid, dm_rdata, io_in_valid, io_in_data, io_out_ready
   );
endinterface

// File: rtl/load_store_align.sv
// Byte-lane steering: store byte-enables and data replication, load lane
// extraction with sign/zero extension, and alignment/encoding fault detection.
module load_store_align
   import mem_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [1:0]        addr_lo,
   input  logic [2:0]        funct3,
   input  logic              is_load,
   input  logic [XLEN-1:0]   wdata,
   input  logic [XLEN-1:0]   rdata,
   output logic [XLEN/8-1:0] be,
   output logic [XLEN-1:0]   wdata_o,
   output logic [XLEN-1:0]   rdata_o,
   output logic              err
);
   localparam int NB = XLEN / 8;

   logic [XLEN-1:0] sh;
   assign sh = rdata >> {addr_lo, 3'b000};

   always_comb begin
      be      = '0;
      wdata_o = wdata;
      rdata_o = '0;
      err     = 1'b0;
      case (funct3)
         F3_B: begin
            be      = NB'(1) << addr_lo;
            wdata_o = {NB{wdata[7:0]}};
            rdata_o = {{(XLEN-8){sh[7]}}, sh[7:0]};
         end
         F3_H: begin
            be      = NB'(3) << addr_lo;
            wdata_o = {(NB/2){wdata[15:0]}};
            rdata_o = {{(XLEN-16){sh[15]}}, sh[15:0]};
            err     = addr_lo[0];
         end
         F3_W: begin
            be      = '1;
            rdata_o = sh;
            err     = (addr_lo != 2'b00);
         end
         // unsigned variants exist only for loads
         F3_BU: begin
            rdata_o = {{(XLEN-8){1'b0}}, sh[7:0]};
            err     = !is_load;
         end
         F3_HU: begin
            rdata_o = {{(XLEN-16){1'b0}}, sh[15:0]};
            err     = !is_load || addr_lo[0];
         end
         default: err = 1'b1;
      endcase
   end
endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: sequences data-memory and MMIO accesses, stalls upstream
// while an access is outstanding, and registers load results for writeback.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int              XLEN          = 32,
   parameter int              ADDR_W        = 20,
   parameter int              RD_W          = 5,
   parameter logic [XLEN-1:0] MMIO_IN_ADDR  = XLEN'(MMIO_IN_DEF),
   parameter logic [XLEN-1:0] MMIO_OUT_ADDR = XLEN'(MMIO_OUT_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic              ex_mem_read,
   input  logic              ex_mem_write,
   input  logic [2:0]        ex_funct3,
   input  logic [XLEN-1:0]   ex_addr,
   input  logic [XLEN-1:0]   ex_wdata,
   input  logic [RD_W-1:0]   ex_rd,
   mem_access_unit_if.master bus,
   output logic              stall_m,
   output logic              misalign_m,
   output logic              wb_valid,
   output logic [RD_W-1:0]   wb_rd,
   output logic [XLEN-1:0]   wb_load_data
);
   mau_state_e        state, idle_nxt;
   logic [1:0]        lo_q;
   logic [2:0]        f3_q;
   logic              ld_q;
   logic [RD_W-1:0]   rd_q;
   logic [7:0]        io_byte_q;
   logic              req_q, we_q, io_in_rdy_q, io_out_vld_q;
   logic [ADDR_W-1:0] addr_q;
   logic [XLEN-1:0]   dmw_q;
   logic [XLEN/8-1:0] be_q;

   logic              mem_op, hit_in, hit_out;
   logic [1:0]        al_lo;
   logic [2:0]        al_f3;
   logic              al_ld, al_err;
   logic [XLEN/8-1:0] al_be;
   logic [XLEN-1:0]   al_wdata, al_rdata;

   assign mem_op  = ex_valid && (ex_mem_read || ex_mem_write);
   assign hit_in  = (ex_addr == MMIO_IN_ADDR);
   assign hit_out = (ex_addr == MMIO_OUT_ADDR);

   // Aligner sees the incoming op while idle, the latched op otherwise.
   always_comb begin
      if (state == ST_IDLE) begin
         al_lo = ex_addr[1:0];
         al_f3 = ex_funct3;
         al_ld = ex_mem_read;
      end else begin
         al_lo = lo_q;
         al_f3 = f3_q;
         al_ld = ld_q;
      end
   end

   load_store_align #(.XLEN(XLEN)) u_align (
      .addr_lo (al_lo),
      .funct3  (al_f3),
      .is_load (al_ld),
      .wdata   (ex_wdata),
      .rdata   (bus.dm_rdata),
      .be      (al_be),
      .wdata_o (al_wdata),
      .rdata_o (al_rdata),
      .err     (al_err)
   );

   // Faults and MMIO accesses with no side effect finish in the IDLE cycle.
   always_comb begin
      idle_nxt = ST_IDLE;
      if (al_err)           idle_nxt = ST_IDLE;
      else if (ex_mem_read) idle_nxt = hit_in  ? ST_IO_IN  : (hit_out ? ST_IDLE : ST_REQ);
      else                  idle_nxt = hit_out ? ST_IO_OUT : (hit_in  ? ST_IDLE : ST_REQ);
   end

   always_comb begin
      stall_m = 1'b0;
      if (!rst) begin
         case (state)
            ST_IDLE:   stall_m = mem_op && (idle_nxt != ST_IDLE);
            ST_REQ:    stall_m = !(bus.dm_ready && !ld_q);
            ST_RESP:   stall_m = !bus.dm_rvalid;
            ST_IO_IN:  stall_m = !bus.io_in_valid;
            ST_IO_OUT: stall_m = !bus.io_out_ready;
            default:   stall_m = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         lo_q         <= '0;
         f3_q         <= '0;
         ld_q         <= 1'b0;
         rd_q         <= '0;
         io_byte_q    <= '0;
         req_q        <= 1'b0;
         we_q         <= 1'b0;
         io_in_rdy_q  <= 1'b0;
         io_out_vld_q <= 1'b0;
         addr_q       <= '0;
         dmw_q        <= '0;
         be_q         <= '0;
         misalign_m   <= 1'b0;
         wb_valid     <= 1'b0;
         wb_rd        <= '0;
         wb_load_data <= '0;
      end else begin
         wb_valid   <= 1'b0;
         misalign_m <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (mem_op) begin
                  lo_q         <= ex_addr[1:0];
                  f3_q         <= ex_funct3;
                  ld_q         <= ex_mem_read;
                  rd_q         <= ex_rd;
                  io_byte_q    <= ex_wdata[7:0];
                  addr_q       <= ex_addr[ADDR_W+1:2];
                  dmw_q        <= al_wdata;
                  be_q         <= al_be;
                  misalign_m   <= al_err;
                  state        <= idle_nxt;
                  req_q        <= (idle_nxt == ST_REQ);
                  we_q         <= (idle_nxt == ST_REQ) && !ex_mem_read;
                  io_in_rdy_q  <= (idle_nxt == ST_IO_IN);
                  io_out_vld_q <= (idle_nxt == ST_IO_OUT);
                  if (idle_nxt == ST_IDLE && ex_mem_read && !al_err) begin
                     wb_valid     <= 1'b1;
                     wb_rd        <= ex_rd;
                     wb_load_data <= '0;
                  end
               end else if (ex_valid) begin
                  wb_valid     <= 1'b1;
                  wb_rd        <= ex_rd;
                  wb_load_data <= '0;
               end
            end
            ST_REQ: if (bus.dm_ready) begin
               req_q <= 1'b0;
               we_q  <= 1'b0;
               state <= ld_q ? ST_RESP : ST_IDLE;
            end
            ST_RESP: if (bus.dm_rvalid) begin
               state        <= ST_IDLE;
               wb_valid     <= 1'b1;
               wb_rd        <= rd_q;
               wb_load_data <= al_rdata;
            end
            ST_IO_IN: if (bus.io_in_valid) begin
               state        <= ST_IDLE;
               io_in_rdy_q  <= 1'b0;
               wb_valid     <= 1'b1;
               wb_rd        <= rd_q;
               wb_load_data <= bus.io_in_data;
            end
            ST_IO_OUT: if (bus.io_out_ready) begin
               state        <= ST_IDLE;
               io_out_vld_q <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.dm_req       = req_q;
   assign bus.dm_we        = we_q;
   assign bus.dm_addr      = addr_q;
   assign bus.dm_wdata     = dmw_q;
   assign bus.dm_be        = be_q;
   assign bus.io_in_ready  = io_in_rdy_q;
   assign bus.io_out_valid = io_out_vld_q;
   assign bus.io_out_data  = io_byte_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: reset, loads/stores, alignment faults,
// MMIO ports, pass-through ops and reset during an outstanding access.
module tb_mem_access_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_mem_read, ex_mem_write;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_addr, ex_wdata;
   logic [4:0]  ex_rd;
   logic        stall_m, misalign_m, wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_load_data;
   int          vecs = 0;
   int          errs = 0;

   mem_access_unit_if #(.XLEN(32), .ADDR_W(20)) bus ();

   mem_access_unit #(.XLEN(32), .ADDR_W(20), .RD_W(5)) dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3), .ex_addr(ex_addr),
      .ex_wdata(ex_wdata), .ex_rd(ex_rd), .bus(bus), .stall_m(stall_m),
      .misalign_m(misalign_m), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_load_data(wb_load_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic issue(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
      ex_valid = 1'b1; ex_mem_read = rd_en; ex_mem_write = wr_en;
      ex_funct3 = f3; ex_addr = a; ex_wdata = wd; ex_rd = rd;
   endtask

   task automatic idle_ex();
      ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd1);
      tick(); tick(); settle();
      vecs++; if (stall_m !== 1'b0) begin errs++; $display("FAIL rst_stall: got %b want 0", stall_m); end
      vecs++; if (bus.dm_req !== 1'b0 || bus.dm_we !== 1'b0) begin errs++; $display("FAIL rst_req: got %b%b want 00", bus.dm_req, bus.dm_we); end
      vecs++; if (bus.dm_addr !== 20'h0 || bus.dm_wdata !== 32'h0 || bus.dm_be !== 4'h0) begin errs++; $display("FAIL rst_bus: got %h %h %h want 0", bus.dm_addr, bus.dm_wdata, bus.dm_be); end
      vecs++; if (wb_valid !== 1'b0 || wb_rd !== 5'd0 || wb_load_data !== 32'h0 || misalign_m !== 1'b0) begin errs++; $display("FAIL rst_wb: got %b %h %h %b want 0", wb_valid, wb_rd, wb_load_data, misalign_m); end
      vecs++; if (bus.io_in_ready !== 1'b0 || bus.io_out_valid !== 1'b0) begin errs++; $display("FAIL rst_io: got %b%b want 00", bus.io_in_ready, bus.io_out_valid); end
      idle_ex();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_lw();
      int stalls = 0;
      issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd7);
      settle(); if (stall_m) stalls++;
      tick(); idle_ex(); bus.dm_ready = 1'b1; settle(); if (stall_m) stalls++;
      vecs++; if (bus.dm_req !== 1'b1 || bus.dm_we !== 1'b0 || bus.dm_addr !== 20'h4) begin errs++; $display("FAIL lw_req: got req%b we%b addr%h want 1 0 4", bus.dm_req, bus.dm_we, bus.dm_addr); end
      tick(); bus.dm_ready = 1'b0; settle(); if (stall_m) stalls++;
      vecs++; if (bus.dm_req !== 1'b0) begin errs++; $display("FAIL lw_req_drop: got %b want 0", bus.dm_req); end
      tick(); bus.dm_rvalid = 1'b1; bus.dm_rdata = 32'hDEADBEEF; settle(); if (stall_m) stalls++;
      tick(); bus.dm_rvalid = 1'b0; settle();
      vecs++; if (stalls != 3) begin errs++; $display("FAIL lw_stall_cycles: got %0d want 3", stalls); end
      vecs++; if (wb_valid !== 1'b1 || wb_load_data !== 32'hDEADBEEF || wb_rd !== 5'd7) begin errs++; $display("FAIL lw_wb: got %b %h %0d want 1 deadbeef 7", wb_valid, wb_load_data, wb_rd); end
      tick(); settle();
      vecs++; if (wb_valid !== 1'b0) begin errs++; $display("FAIL lw_wb_pulse: got %b want 0", wb_valid); end
   endtask

   task automatic test_sb();
      issue(1'b0, 1'b1, 3'b000, 32'h13, 32'h000000A5, 5'd2);
      settle();
      vecs++; if (stall_m !== 1'b1) begin errs++; $display("FAIL sb_idle_stall: got %b want 1", stall_m); end
      tick(); idle_ex(); settle();
      vecs++; if (bus.dm_req !== 1'b1 || bus.dm_we !== 1'b1 || bus.dm_be !== 4'b1000) begin errs++; $display("FAIL sb_ctl: got req%b we%b be%b want 1 1 1000", bus.dm_req, bus.dm_we, bus.dm_be); end
      vecs++; if (bus.dm_wdata !== 32'hA5A5A5A5 || bus.dm_addr !== 20'h4) begin errs++; $display("FAIL sb_data: got %h @%h want a5a5a5a5 @4", bus.dm_wdata, bus.dm_addr); end
      vecs++; if (stall_m !== 1'b1) begin errs++; $display("FAIL sb_wait_stall: got %b want 1", stall_m); end
      tick(); bus.dm_ready = 1'b1; settle();
      vecs++; if (bus.dm_req !== 1'b1 || stall_m !== 1'b0) begin errs++; $display("FAIL sb_done: got req%b stall%b want 1 0", bus.dm_req, stall_m); end
      tick(); bus.dm_ready = 1'b0; settle();
      vecs++; if (bus.dm_req !== 1'b0 || wb_valid !== 1'b0) begin errs++; $display("FAIL sb_after: got req%b wb%b want 0 0", bus.dm_req, wb_valid); end
      // half and word store byte-enables
      issue(1'b0, 1'b1, 3'b001, 32'h22, 32'h0000BEEF, 5'd0);
      tick(); idle_ex(); bus.dm_ready = 1'b1; settle();
      vecs++; if (bus.dm_be !== 4'b1100 || bus.dm_wdata !== 32'hBEEFBEEF) begin errs++; $display("FAIL sh_lanes: got %b %h want 1100 beefbeef", bus.dm_be, bus.dm_wdata); end
      tick(); bus.dm_ready = 1'b0;
      issue(1'b0, 1'b1, 3'b010, 32'h24, 32'h12345678, 5'd0);
      tick(); idle_ex(); bus.dm_ready = 1'b1; settle();
      vecs++; if (bus.dm_be !== 4'b1111 || bus.dm_wdata !== 32'h12345678 || bus.dm_addr !== 20'h9) begin errs++; $display("FAIL sw_lanes: got %b %h %h want 1111 12345678 9", bus.dm_be, bus.dm_wdata, bus.dm_addr); end
      tick(); bus.dm_ready = 1'b0;
   endtask

   task automatic test_load_ext();
      logic [2:0]  f3 [5] = '{3'b001, 3'b101, 3'b000, 3'b100, 3'b010};
      logic [31:0] ad [5] = '{32'h22, 32'h22, 32'h11, 32'h13, 32'h20};
      logic [31:0] rdv[5] = '{32'h80010000, 32'h80010000, 32'h00008000, 32'h7F000000, 32'h12345678};
      logic [31:0] exp[5] = '{32'hFFFF8001, 32'h00008001, 32'hFFFFFF80, 32'h0000007F, 32'h12345678};
      for (int i = 0; i < 5; i++) begin
         issue(1'b1, 1'b0, f3[i], ad[i], 32'h0, 5'(i + 10));
         tick(); idle_ex(); bus.dm_ready = 1'b1; settle();
         vecs++; if (stall_m !== 1'b1 || bus.dm_req !== 1'b1) begin errs++; $display("FAIL ld%0d_req: got stall%b req%b want 1 1", i, stall_m, bus.dm_req); end
         tick(); bus.dm_ready = 1'b0; bus.dm_rvalid = 1'b1; bus.dm_rdata = rdv[i]; settle();
         vecs++; if (stall_m !== 1'b0) begin errs++; $display("FAIL ld%0d_resp_stall: got %b want 0", i, stall_m); end
         tick(); bus.dm_rvalid = 1'b0; settle();
         vecs++; if (wb_valid !== 1'b1 || wb_load_data !== exp[i] || wb_rd !== 5'(i + 10)) begin errs++; $display("FAIL ld%0d_data: got %b %h want 1 %h", i, wb_valid, wb_load_data, exp[i]); end
      end
   endtask

   task automatic test_misalign();
      logic        wr [3] = '{1'b0, 1'b1, 1'b0};
      logic [2:0]  f3 [3] = '{3'b010, 3'b001, 3'b011};
      logic [31:0] ad [3] = '{32'h6, 32'h1, 32'h8};
      for (int i = 0; i < 3; i++) begin
         issue(!wr[i], wr[i], f3[i], ad[i], 32'h0, 5'd4);
         settle();
         vecs++; if (stall_m !== 1'b0) begin errs++; $display("FAIL mis%0d_idle_stall: got %b want 0", i, stall_m); end
         tick(); idle_ex(); settle();
         vecs++; if (misalign_m !== 1'b1 || bus.dm_req !== 1'b0 || stall_m !== 1'b0 || wb_valid !== 1'b0) begin errs++; $display("FAIL mis%0d: got mis%b req%b stall%b wb%b want 1 0 0 0", i, misalign_m, bus.dm_req, stall_m, wb_valid); end
         tick(); settle();
         vecs++; if (misalign_m !== 1'b0) begin errs++; $display("FAIL mis%0d_pulse: got %b want 0", i, misalign_m); end
      end
   endtask

   task automatic test_mmio();
      issue(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 5'd3);
      tick(); idle_ex();
      for (int c = 0; c < 5; c++) begin
         settle();
         vecs++; if (bus.io_in_ready !== 1'b1 || stall_m !== 1'b1) begin errs++; $display("FAIL ioin_wait%0d: got rdy%b stall%b want 1 1", c, bus.io_in_ready, stall_m); end
         tick();
      end
      bus.io_in_valid = 1'b1; bus.io_in_data = 32'h41; settle();
      vecs++; if (stall_m !== 1'b0) begin errs++; $display("FAIL ioin_done_stall: got %b want 0", stall_m); end
      tick(); bus.io_in_valid = 1'b0; settle();
      vecs++; if (wb_valid !== 1'b1 || wb_load_data !== 32'h41 || wb_rd !== 5'd3 || bus.io_in_ready !== 1'b0) begin errs++; $display("FAIL ioin_wb: got %b %h %0d rdy%b want 1 41 3 0", wb_valid, wb_load_data, wb_rd, bus.io_in_ready); end
      issue(1'b0, 1'b1, 3'b010, 32'h4, 32'h123456C3, 5'd0);
      tick(); idle_ex(); settle();
      vecs++; if (bus.io_out_valid !== 1'b1 || bus.io_out_data !== 8'hC3 || stall_m !== 1'b1 || bus.dm_req !== 1'b0) begin errs++; $display("FAIL ioout: got v%b d%h stall%b req%b want 1 c3 1 0", bus.io_out_valid, bus.io_out_data, stall_m, bus.dm_req); end
      bus.io_out_ready = 1'b1; settle();
      vecs++; if (stall_m !== 1'b0) begin errs++; $display("FAIL ioout_done: got %b want 0", stall_m); end
      tick(); bus.io_out_ready = 1'b0; settle();
      vecs++; if (bus.io_out_valid !== 1'b0 || wb_valid !== 1'b0) begin errs++; $display("FAIL ioout_after: got v%b wb%b want 0 0", bus.io_out_valid, wb_valid); end
      // wrong-direction MMIO accesses are no-ops
      issue(1'b0, 1'b1, 3'b010, 32'h0, 32'hFFFFFFFF, 5'd0); settle();
      vecs++; if (stall_m !== 1'b0) begin errs++; $display("FAIL st_in_stall: got %b want 0", stall_m); end
      tick(); settle();
      vecs++; if (bus.dm_req !== 1'b0 || bus.io_in_ready !== 1'b0 || bus.io_out_valid !== 1'b0 || wb_valid !== 1'b0) begin errs++; $display("FAIL st_in_noop: got %b%b%b%b want 0000", bus.dm_req, bus.io_in_ready, bus.io_out_valid, wb_valid); end
      issue(1'b1, 1'b0, 3'b010, 32'h4, 32'h0, 5'd9); settle();
      vecs++; if (stall_m !== 1'b0) begin errs++; $display("FAIL ld_out_stall: got %b want 0", stall_m); end
      tick(); idle_ex(); settle();
      vecs++; if (wb_valid !== 1'b1 || wb_load_data !== 32'h0 || wb_rd !== 5'd9 || bus.dm_req !== 1'b0) begin errs++; $display("FAIL ld_out_wb: got %b %h %0d req%b want 1 0 9 0", wb_valid, wb_load_data, wb_rd, bus.dm_req); end
      tick();
   endtask

   task automatic test_passthru();
      issue(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, 5'd12); settle();
      vecs++; if (stall_m !== 1'b0) begin errs++; $display("FAIL pass_stall: got %b want 0", stall_m); end
      tick(); idle_ex(); settle();
      vecs++; if (wb_valid !== 1'b1 || wb_rd !== 5'd12 || wb_load_data !== 32'h0 || bus.dm_req !== 1'b0) begin errs++; $display("FAIL pass_wb: got %b %0d %h req%b want 1 12 0 0", wb_valid, wb_rd, wb_load_data, bus.dm_req); end
      tick();
   endtask

   task automatic test_back_to_back();
      issue(1'b1, 1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 5'd5);
      tick(); idle_ex(); bus.dm_ready = 1'b1; settle();
      vecs++; if (bus.dm_req !== 1'b1 || bus.dm_we !== 1'b0 || bus.dm_addr !== 20'hC) begin errs++; $display("FAIL rw_as_load: got req%b we%b addr%h want 1 0 c", bus.dm_req, bus.dm_we, bus.dm_addr); end
      tick(); bus.dm_ready = 1'b0; bus.dm_rvalid = 1'b1; bus.dm_rdata = 32'h0BADF00D;
      issue(1'b1, 1'b0, 3'b010, 32'h34, 32'h0, 5'd6); settle();
      tick(); bus.dm_rvalid = 1'b0; idle_ex(); bus.dm_ready = 1'b1; settle();
      vecs++; if (wb_valid !== 1'b1 || wb_load_data !== 32'h0BADF00D || wb_rd !== 5'd5) begin errs++; $display("FAIL b2b_first: got %b %h %0d want 1 0badf00d 5", wb_valid, wb_load_data, wb_rd); end
      vecs++; if (bus.dm_req !== 1'b0) begin errs++; $display("FAIL b2b_ignored: got req%b want 0", bus.dm_req); end
      tick(); bus.dm_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      issue(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 5'd8);
      tick(); idle_ex(); settle();
      vecs++; if (bus.dm_req !== 1'b1) begin errs++; $display("FAIL rm_req: got %b want 1", bus.dm_req); end
      rst = 1'b1; #1;
      vecs++; if (bus.dm_req !== 1'b0 || stall_m !== 1'b0 || bus.dm_addr !== 20'h0 || wb_valid !== 1'b0) begin errs++; $display("FAIL rm_async: got req%b stall%b addr%h wb%b want 0 0 0 0", bus.dm_req, stall_m, bus.dm_addr, wb_valid); end
      tick(); rst = 1'b0; tick();
      bus.dm_rvalid = 1'b1; bus.dm_rdata = 32'h55AA55AA; settle();
      vecs++; if (stall_m !== 1'b0) begin errs++; $display("FAIL rm_late_stall: got %b want 0", stall_m); end
      tick(); bus.dm_rvalid = 1'b0; settle();
      vecs++; if (wb_valid !== 1'b0 || wb_load_data !== 32'h0) begin errs++; $display("FAIL rm_late_rvalid: got %b %h want 0 0", wb_valid, wb_load_data); end
   endtask

   initial begin
      idle_ex();
      ex_funct3 = 3'b0; ex_addr = '0; ex_wdata = '0; ex_rd = '0;
      bus.dm_ready = 1'b0; bus.dm_rvalid = 1'b0; bus.dm_rdata = '0;
      bus.io_in_valid = 1'b0; bus.io_in_data = '0; bus.io_out_ready = 1'b0;
      test_reset();
      test_lw();
      test_sb();
      test_load_ext();
      test_misalign();
      test_mmio();
      test_passthru();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
